// File: rtl/maj_oversample_rx_pkg.sv
// Shared types and constants for the 4x oversampling serial receiver.
package maj_oversample_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int unsigned SAMPLES_PER_BIT = 4;

  localparam state_e STATE_RST_VAL = IDLE;
  localparam logic   SYNC_RST_VAL  = 1'b1;
  localparam logic   PULSE_RST_VAL = 1'b0;

endpackage

// File: rtl/maj_oversample_rx_majority4.sv
// 4-input majority voter: 1 only when at least three inputs are 1 (2/2 ties vote 0).
module majority4 (
  input  logic [3:0] samples_i,
  output logic       vote_o
);

  logic [2:0] ones;

  always_comb begin
    ones   = 3'(samples_i[0]) + 3'(samples_i[1]) + 3'(samples_i[2]) + 3'(samples_i[3]);
    vote_o = (ones >= 3'd3);
  end

endmodule

// File: rtl/maj_oversample_rx.sv
// Serial receiver: 2-FF sync, 4x oversampling window, majority vote per bit,
// LSB-first framing with stop-bit check.
module maj_oversample_rx
  import maj_oversample_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned CLKS_PER_SAMPLE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned DIV_W  = $clog2(CLKS_PER_SAMPLE);
  localparam int unsigned SLOT_W = $clog2(SAMPLES_PER_BIT);
  localparam int unsigned CNT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLKS_PER_SAMPLE - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SAMPLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic                 rx_s;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [2:0]           win_q, win_d;
  logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
  logic                 vote_q, shift_en_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS:0]   shift_ext;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 sample_tick, vote_tick, vote;

  assign rx_s = sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= SYNC_RST_VAL;
      sync2_q <= SYNC_RST_VAL;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  // Slot 3 is taken straight from rx_s so the vote lands on the capture edge.
  majority4 u_vote (
    .samples_i ({win_q[0], win_q[1], win_q[2], rx_s}),
    .vote_o    (vote)
  );

  always_comb begin
    sample_tick = (state_q != IDLE) && (div_q == DIV_MAX);
    vote_tick   = sample_tick && (slot_q == LAST_SLOT);
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= STATE_RST_VAL;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (vote_tick) state_d = vote ? IDLE : DATA;
      DATA:    if (vote_tick && (bitcnt_q == LAST_BIT)) state_d = STOP;
      STOP:    if (vote_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    data_out_d = data_out_q;
    if (vote_tick && (state_q == STOP)) begin
      valid_d = vote;
      ferr_d  = !vote;
      if (vote) data_out_d = shift_q;
    end
  end

  // Counters are held clear in IDLE, so entry to START always begins at zero.
  always_comb begin
    div_d    = div_q;
    slot_d   = slot_q;
    win_d    = win_q;
    bitcnt_d = bitcnt_q;
    if (state_q == IDLE) begin
      div_d    = '0;
      slot_d   = '0;
      bitcnt_d = '0;
    end else if (sample_tick) begin
      div_d  = '0;
      slot_d = slot_q + SLOT_W'(1);
      case (slot_q)
        2'd0:    win_d[0] = rx_s;
        2'd1:    win_d[1] = rx_s;
        2'd2:    win_d[2] = rx_s;
        default: ;
      endcase
      if (vote_tick && (state_q == DATA)) bitcnt_d = bitcnt_q + CNT_W'(1);
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // The voted data bit enters the shifter one clock after its decision edge.
  always_comb begin
    shift_ext = {vote_q, shift_q};
    shift_d   = shift_en_q ? shift_ext[DATA_BITS:1] : shift_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      slot_q     <= '0;
      win_q      <= '0;
      bitcnt_q   <= '0;
      vote_q     <= 1'b0;
      shift_en_q <= 1'b0;
      shift_q    <= '0;
      data_out_q <= '0;
      valid_q    <= PULSE_RST_VAL;
      ferr_q     <= PULSE_RST_VAL;
    end else begin
      div_q      <= div_d;
      slot_q     <= slot_d;
      win_q      <= win_d;
      bitcnt_q   <= bitcnt_d;
      if (vote_tick) vote_q <= vote;
      shift_en_q <= vote_tick && (state_q == DATA);
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_maj_oversample_rx.sv
// Bench: per-clock rx_in waveforms checked cycle-by-cycle against a sample-point model.
module tb_maj_oversample_rx;

  localparam int DATA_BITS = 8;
  localparam int CPS       = 4;
  localparam int BP        = 4 * CPS;
  localparam int MAXL      = 4096;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 rx_in = 1'b1;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid, frame_err, busy;

  int checks = 0;
  int errors = 0;

  logic                 wave [0:MAXL-1];
  int                   wlen;
  logic [3:0]           nmask [0:DATA_BITS+1];
  logic                 eb [0:MAXL-1];
  logic                 ev [0:MAXL-1];
  logic                 ef [0:MAXL-1];
  logic [DATA_BITS-1:0] ed [0:MAXL-1];
  logic [DATA_BITS-1:0] exp_data = '0;

  maj_oversample_rx #(
    .DATA_BITS       (DATA_BITS),
    .CLKS_PER_SAMPLE (CPS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic clear_wave();
    wlen = 0;
  endtask

  task automatic clear_mask();
    for (int k = 0; k < DATA_BITS + 2; k++) nmask[k] = 4'b0000;
  endtask

  task automatic add_level(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      wave[wlen] = lvl;
      wlen++;
    end
  endtask

  // Start bit is BP+1 clocks so every bit's four sample points fall inside that bit.
  task automatic add_frame(input logic [15:0] data, input logic stopv);
    int   f0;
    int   k;
    logic lvl;
    f0 = wlen;
    for (int i = 0; i < BP * (DATA_BITS + 2) + 1; i++) begin
      k = (i == 0) ? 0 : (i - 1) / BP;
      if (k == 0)              lvl = 1'b0;
      else if (k <= DATA_BITS) lvl = data[k-1];
      else                     lvl = stopv;
      wave[f0 + i] = lvl;
    end
    for (int kk = 0; kk < DATA_BITS + 2; kk++)
      for (int j = 0; j < 4; j++)
        if (nmask[kk][j]) wave[f0 + BP*kk + CPS*(j+1)] = !wave[f0 + BP*kk + CPS*(j+1)];
    wlen = f0 + BP * (DATA_BITS + 2) + 1;
  endtask

  function automatic int sample_at(input int i);
    if (i < wlen) return wave[i] ? 1 : 0;
    return 1;
  endfunction

  // rx_in driven in slot c is seen by the FSM two edges later; bit k's samples
  // sit at offsets BP*(k-1)+CPS*{1..4} from the first low slot e.
  task automatic build_expect();
    int                   e, d_edge, ones, kend;
    logic                 v, stopv, abort;
    logic [DATA_BITS-1:0] d;
    for (int c = 0; c < wlen; c++) begin
      eb[c] = 1'b0; ev[c] = 1'b0; ef[c] = 1'b0; ed[c] = exp_data;
    end
    e = 0;
    while (e < wlen) begin
      if (wave[e] == 1'b0) begin
        d = '0; abort = 1'b0; stopv = 1'b0;
        for (int k = 1; k <= DATA_BITS + 2; k++) begin
          if (!abort) begin
            ones = 0;
            for (int j = 1; j <= 4; j++) ones += sample_at(e + BP*(k-1) + CPS*j);
            v = (ones >= 3);
            if (k == 1) abort = v;
            else if (k <= DATA_BITS + 1) d[k-2] = v;
            else stopv = v;
          end
        end
        kend   = abort ? 1 : DATA_BITS + 2;
        d_edge = e + 2 + BP * kend;
        for (int c = e + 2; c < d_edge && c < wlen; c++) eb[c] = 1'b1;
        if (!abort && d_edge < wlen) begin
          if (stopv) begin
            ev[d_edge] = 1'b1;
            for (int c = d_edge; c < wlen; c++) ed[c] = d;
          end else begin
            ef[d_edge] = 1'b1;
          end
        end
        e = d_edge - 1;
      end else begin
        e++;
      end
    end
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic run_wave(input string name, input int nrun);
    int n;
    build_expect();
    n = (nrun < wlen) ? nrun : wlen;
    for (int c = 0; c < n; c++) begin
      rx_in = wave[c];
      @(posedge clk);
      #1;
      checks++;
      if (busy !== eb[c]) begin
        errors++;
        $display("FAIL %s busy c=%0d got %b exp %b", name, c, busy, eb[c]);
      end
      checks++;
      if (valid !== ev[c]) begin
        errors++;
        $display("FAIL %s valid c=%0d got %b exp %b", name, c, valid, ev[c]);
      end
      checks++;
      if (frame_err !== ef[c]) begin
        errors++;
        $display("FAIL %s frame_err c=%0d got %b exp %b", name, c, frame_err, ef[c]);
      end
      checks++;
      if (data_out !== ed[c]) begin
        errors++;
        $display("FAIL %s data_out c=%0d got %h exp %h", name, c, data_out, ed[c]);
      end
      checks++;
      if (valid && frame_err) begin
        errors++;
        $display("FAIL %s excl c=%0d got valid=1 frame_err=1 exp not both", name, c);
      end
    end
    if (n == wlen) exp_data = ed[wlen-1];
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, valid, frame_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000", {busy, valid, frame_err});
    end
    checks++;
    if (data_out !== '0) begin
      errors++;
      $display("FAIL reset_data got %h exp 00", data_out);
    end
    rst = 1'b0;
    exp_data = '0;
    clear_wave(); add_level(1'b1, 4);
    run_wave("post_reset_idle", MAXL);
  endtask

  task automatic test_mid_frame_reset();
    clear_wave(); clear_mask();
    add_level(1'b1, 4);
    add_frame(16'h005A, 1'b1);
    add_level(1'b1, 8);
    // stop partway through data bit 3 (between its decision edges)
    run_wave("midrst_pre", 4 + 2 + BP*4 + 7);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, valid, frame_err} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_ctrl got %b exp 000", {busy, valid, frame_err});
    end
    checks++;
    if (data_out !== '0) begin
      errors++;
      $display("FAIL midrst_data got %h exp 00", data_out);
    end
    rx_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_data = '0;
    clear_wave(); add_level(1'b1, 6);
    run_wave("midrst_post", MAXL);
  endtask

  task automatic test_clean_frame();
    clear_wave(); clear_mask();
    add_level(1'b1, 4);
    add_frame(16'h00A5, 1'b1);
    add_level(1'b1, 8);
    run_wave("clean_A5", MAXL);
    checks++;
    if (data_out !== 8'hA5) begin
      errors++;
      $display("FAIL clean_final got %h exp a5", data_out);
    end
  endtask

  task automatic test_noise();
    clear_wave(); clear_mask();
    for (int k = 1; k <= DATA_BITS; k++) nmask[k][$urandom_range(0, 3)] = 1'b1;
    add_level(1'b1, 3);
    add_frame(16'h003C, 1'b1);
    add_level(1'b1, 8);
    run_wave("noise_3C", MAXL);
    checks++;
    if (data_out !== 8'h3C) begin
      errors++;
      $display("FAIL noise_final got %h exp 3c", data_out);
    end
  endtask

  task automatic test_false_start();
    clear_wave();
    add_level(1'b1, 4);
    add_level(1'b0, CPS);
    add_level(1'b1, 30);
    run_wave("false_start", MAXL);
  endtask

  task automatic test_bad_stop();
    logic [DATA_BITS-1:0] prior;
    prior = exp_data;
    clear_wave(); clear_mask();
    add_level(1'b1, 2);
    add_frame(16'h000F, 1'b0);
    add_level(1'b1, 8);
    run_wave("bad_stop", MAXL);
    checks++;
    if (data_out !== prior) begin
      errors++;
      $display("FAIL bad_stop_keep got %h exp %h", data_out, prior);
    end
  endtask

  task automatic test_back_to_back();
    clear_wave(); clear_mask();
    add_level(1'b1, 4);
    nmask[1] = 4'b0011;
    add_frame(16'h00FF, 1'b1);
    clear_mask();
    add_frame(16'h0081, 1'b1);
    add_level(1'b1, 8);
    run_wave("tie_b2b", MAXL);
    checks++;
    if (data_out !== 8'h81) begin
      errors++;
      $display("FAIL b2b_final got %h exp 81", data_out);
    end
  endtask

  task automatic test_random();
    int r, j1;
    clear_wave();
    add_level(1'b1, 3);
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        add_level(1'b0, $urandom_range(1, 8));
        add_level(1'b1, BP + 4);
      end else begin
        clear_mask();
        for (int k = 0; k < DATA_BITS + 2; k++) begin
          r  = $urandom_range(0, 7);
          j1 = $urandom_range(0, 3);
          if (r < 3) nmask[k][j1] = 1'b1;
          else if (r == 3 && k >= 1) begin
            nmask[k][j1] = 1'b1;
            nmask[k][(j1 + 1) % 4] = 1'b1;
          end
        end
        add_frame(16'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0));
        add_level(1'b1, $urandom_range(0, 5));
      end
    end
    add_level(1'b1, 8);
    run_wave("random", MAXL);
  endtask

  initial begin
    test_reset();
    test_mid_frame_reset();
    test_clean_frame();
    test_noise();
    test_false_start();
    test_bad_stop();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
